// File: rtl/fpga_config_receiver.sv
// Fabric configuration sink: stores one-hot selected frames, checks load order,
// reports done/error, gates the fabric flip-flop enable and offers frame readback.
module fpga_config_receiver #(
    parameter int NUM_FRAMES = 43,
    parameter int FRAME_W    = 224,
    parameter int AW         = $clog2(NUM_FRAMES)
) (
    input  logic                            clock,
    input  logic                            rst,
    input  logic [NUM_FRAMES-1:0]           configs_en,
    input  logic [FRAME_W-1:0]              configs_in,
    input  logic                            ff_en,
    input  logic                            rd_en,
    input  logic [AW-1:0]                   rd_addr,
    output logic [NUM_FRAMES*FRAME_W-1:0]   config_bits,
    output logic                            fabric_ff_en,
    output logic                            cfg_done,
    output logic                            cfg_err,
    output logic [1:0]                      err_code,
    output logic [$clog2(NUM_FRAMES+1)-1:0] frames_loaded,
    output logic [FRAME_W-1:0]              rd_data,
    output logic                            rd_valid
);

    localparam int FLW = $clog2(NUM_FRAMES+1);
    localparam logic [AW:0] LAST_IDX = (AW+1)'(NUM_FRAMES - 1);
    localparam logic [AW:0] NF_W = (AW+1)'(NUM_FRAMES);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [FRAME_W-1:0]  frames [NUM_FRAMES];
    logic [AW-1:0]       last;
    logic [AW-1:0]       idx;
    logic                any_en;
    logic                multi_en;
    logic                at_next;
    logic                at_end;
    logic                we;
    logic                fl_clr;
    logic                fl_inc;
    logic                err_set;
    logic [1:0]          err_nxt;
    logic                rd_in_range;

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_FRAMES; i++) begin
            if (configs_en[i]) idx = AW'(i);
        end
    end

    // x & (x-1) is nonzero exactly when more than one bit is set
    assign any_en   = |configs_en;
    assign multi_en = |(configs_en & (configs_en - NUM_FRAMES'(1)));
    assign at_next  = {1'b0, idx} == ({1'b0, last} + (AW+1)'(1));
    assign at_end   = {1'b0, last} == LAST_IDX;

    always_ff @(posedge clock) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        fl_clr    = 1'b0;
        fl_inc    = 1'b0;
        err_set   = 1'b0;
        err_nxt   = 2'b00;
        if (state != ERR && multi_en) begin
            state_nxt = ERR;
            err_set   = 1'b1;
            err_nxt   = 2'b01;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (any_en) begin
                        if (idx == '0) begin
                            we        = 1'b1;
                            fl_clr    = 1'b1;
                            state_nxt = LOAD;
                        end else begin
                            state_nxt = ERR;
                            err_set   = 1'b1;
                            err_nxt   = 2'b10;
                        end
                    end
                end
                LOAD: begin
                    if (!any_en) begin
                        if (at_end) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = ERR;
                            err_set   = 1'b1;
                            err_nxt   = 2'b11;
                        end
                    end else if (idx == last) begin
                        we = 1'b1;
                    end else if (at_next) begin
                        we     = 1'b1;
                        fl_inc = 1'b1;
                    end else begin
                        state_nxt = ERR;
                        err_set   = 1'b1;
                        err_nxt   = 2'b10;
                    end
                end
                ERR: ;
            endcase
        end
    end

    assign rd_in_range = {1'b0, rd_addr} < NF_W;

    always_ff @(posedge clock) begin
        if (rst) begin
            last          <= '0;
            frames_loaded <= '0;
            err_code      <= 2'b00;
            rd_data       <= '0;
            rd_valid      <= 1'b0;
            for (int k = 0; k < NUM_FRAMES; k++) frames[k] <= '0;
        end else begin
            if (we) begin
                frames[idx] <= configs_in;
                last        <= idx;
            end
            if (fl_clr)      frames_loaded <= FLW'(1);
            else if (fl_inc) frames_loaded <= frames_loaded + FLW'(1);
            if (err_set) err_code <= err_nxt;
            rd_valid <= rd_en;
            // reads see the pre-write contents of the same edge
            if (rd_en) rd_data <= rd_in_range ? frames[rd_addr] : '0;
        end
    end

    for (genvar k = 0; k < NUM_FRAMES; k++) begin : g_bits
        assign config_bits[k*FRAME_W +: FRAME_W] = frames[k];
    end

    assign cfg_done     = state == DONE;
    assign cfg_err      = state == ERR;
    assign fabric_ff_en = ff_en & cfg_done;

endmodule

// File: tb/tb_fpga_config_receiver.sv
// Randomized bench for fpga_config_receiver: behavioural load model plus a
// readback scoreboard drained by an independent monitor.
module tb_fpga_config_receiver;

    localparam int N   = 43;
    localparam int W   = 224;
    localparam int AW  = 6;
    localparam int FLW = 6;

    logic              clock = 1'b0;
    logic              rst;
    logic [N-1:0]      configs_en;
    logic [W-1:0]      configs_in;
    logic              ff_en;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [N*W-1:0]    config_bits;
    logic              fabric_ff_en;
    logic              cfg_done;
    logic              cfg_err;
    logic [1:0]        err_code;
    logic [FLW-1:0]    frames_loaded;
    logic [W-1:0]      rd_data;
    logic              rd_valid;

    always #5 clock = ~clock;

    fpga_config_receiver #(.NUM_FRAMES(N), .FRAME_W(W), .AW(AW)) dut (
        .clock(clock), .rst(rst), .configs_en(configs_en),
        .configs_in(configs_in), .ff_en(ff_en), .rd_en(rd_en),
        .rd_addr(rd_addr), .config_bits(config_bits),
        .fabric_ff_en(fabric_ff_en), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .err_code(err_code),
        .frames_loaded(frames_loaded), .rd_data(rd_data),
        .rd_valid(rd_valid)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q [$];

    logic [W-1:0] m_mem [N];
    int           m_fl;
    int           m_last;
    bit           m_loading;
    bit           m_done;
    bit           m_err;
    logic [1:0]   m_code;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N; k++) m_mem[k] = '0;
        m_fl = 0; m_last = 0; m_loading = 0;
        m_done = 0; m_err = 0; m_code = 2'b00;
    endfunction

    function automatic void model_fail(input logic [1:0] code);
        m_err = 1; m_code = code; m_done = 0; m_loading = 0;
    endfunction

    // The legal load is frame 0, then each next index, repeats allowed, then idle.
    function automatic void model_step(input logic [N-1:0] en,
                                       input logic [W-1:0] d);
        int cnt;
        int k;
        if (m_err) return;
        cnt = $countones(en);
        if (cnt > 1) begin
            model_fail(2'b01);
            return;
        end
        if (cnt == 0) begin
            if (m_loading) begin
                m_loading = 0;
                if (m_last == N - 1) m_done = 1;
                else model_fail(2'b11);
            end
            return;
        end
        k = 0;
        for (int i = 0; i < N; i++) if (en[i]) k = i;
        if (m_loading) begin
            if (k == m_last) begin
                m_mem[k] = d;
            end else if (k == m_last + 1) begin
                m_mem[k] = d; m_last = k; m_fl++;
            end else begin
                model_fail(2'b10);
            end
        end else if (k == 0) begin
            m_mem[0] = d; m_last = 0; m_fl = 1;
            m_loading = 1; m_done = 0;
        end else begin
            model_fail(2'b10);
        end
    endfunction

    function automatic logic [W-1:0] rand_frame();
        logic [W-1:0] f;
        for (int i = 0; i < 7; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    function automatic logic [W-1:0] pat(input int k);
        logic [31:0] kk;
        kk = k;
        return {7{kk}};
    endfunction

    function automatic logic [N-1:0] sel(input int k);
        logic [N-1:0] e;
        e = '0;
        e[k] = 1'b1;
        return e;
    endfunction

    task automatic check_status();
        chk("cfg_done", W'(cfg_done), W'(m_done));
        chk("cfg_err", W'(cfg_err), W'(m_err));
        chk("err_code", W'(err_code), W'(m_code));
        chk("frames_loaded", W'(frames_loaded), W'(m_fl));
        chk("fabric_ff_en", W'(fabric_ff_en), W'(ff_en & m_done));
    endtask

    task automatic check_frames();
        for (int k = 0; k < N; k++)
            chk($sformatf("frame%0d", k), config_bits[k*W +: W], m_mem[k]);
    endtask

    task automatic step(input logic [N-1:0] en, input logic [W-1:0] d,
                        input logic r_en, input logic [AW-1:0] r_a);
        configs_en = en;
        configs_in = d;
        rd_en      = r_en;
        rd_addr    = r_a;
        ff_en      = ($urandom_range(0, 3) != 0);
        if (r_en) begin
            if (int'(r_a) < N) exp_q.push_back(m_mem[r_a]);
            else exp_q.push_back('0);
        end
        model_step(en, d);
        @(posedge clock);
        @(negedge clock);
        rd_en = 1'b0;
        check_status();
    endtask

    task automatic stepr(input logic [N-1:0] en, input logic [W-1:0] d);
        step(en, d, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 63)));
    endtask

    task automatic load_frames(input int from, input int upto, input bit rnd);
        logic [W-1:0] d;
        for (int k = from; k <= upto; k++) begin
            d = rnd ? rand_frame() : pat(k);
            stepr(sel(k), d);
            stepr(sel(k), d);
        end
    endtask

    task automatic do_reset(input logic [N-1:0] en);
        rst        = 1'b1;
        configs_en = en;
        configs_in = rand_frame();
        rd_en      = 1'b0;
        @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        configs_en = '0;
        model_reset();
        check_status();
        chk("rd_valid_rst", W'(rd_valid), '0);
        chk("rd_data_rst", rd_data, '0);
        check_frames();
    endtask

    always @(negedge clock) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_unexpected: got rd_valid=1 expected 0");
            end else begin
                chk("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; configs_en = '0; configs_in = '0;
        ff_en = 1'b0; rd_en = 1'b0; rd_addr = '0;
        model_reset();

        do_reset('0);
        load_frames(0, N - 1, 0);
        stepr('0, '0);
        check_frames();
        step('0, '0, 1'b1, AW'(42));
        step('0, '0, 1'b1, AW'(50));
        step('0, '0, 1'b1, AW'(7));
        step('0, '0, 1'b0, '0);

        step(sel(0), '1, 1'b0, '0);
        check_frames();
        step(sel(0), '1, 1'b1, '0);
        load_frames(1, N - 1, 1);
        stepr('0, '0);
        check_frames();

        do_reset('0);
        load_frames(0, 5, 1);
        stepr(N'(3) << 6, rand_frame());
        check_frames();
        for (int i = 0; i < 6; i++) stepr(sel(i), rand_frame());
        for (int a = 0; a < 8; a++) step('0, '0, 1'b1, AW'(a));
        step(sel(7), rand_frame(), 1'b1, AW'(50));
        check_frames();

        do_reset('0);
        load_frames(0, 3, 1);
        stepr(sel(5), rand_frame());
        stepr(sel(4), rand_frame());
        check_frames();

        do_reset('0);
        load_frames(0, 20, 1);
        stepr('0, '0);
        stepr(sel(0), rand_frame());
        check_frames();

        do_reset('0);
        load_frames(0, 9, 1);
        do_reset(sel(10));
        load_frames(0, N - 1, 1);
        stepr('0, '0);
        stepr('0, '0);
        check_frames();

        step('0, '0, 1'b0, '0);
        step('0, '0, 1'b0, '0);
        chk("rd_pending", W'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_config_receiver.md
# fpga_config_receiver

Receiving end of the fabric configuration load interface. It sits inside the `fpga` top and sinks the `configs_en` one-hot frame select and the `configs_in` frame data that the bitstream loader drives. It stores every frame and exposes the assembled configuration to the tiles. It checks that the load sequence is legal, reports completion and errors, gates the fabric `ff_en`, and provides a registered frame readback port.

## Interface
- `NUM_FRAMES`, default 43: number of configuration frames, one per `configs_en` bit.
- `FRAME_W`, default 224: width of one frame in bits.
- `AW`, default `$clog2(NUM_FRAMES)`: frame index width.
- `clock`, input, 1: the only clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `configs_en`, input, NUM_FRAMES: one-hot frame write select; all-zero means idle.
- `configs_in`, input, FRAME_W: frame data, sampled with `configs_en`.
- `ff_en`, input, 1: requested fabric flip-flop enable.
- `rd_en`, input, 1: readback request.
- `rd_addr`, input, AW: frame index to read back.
- `config_bits`, output, NUM_FRAMES*FRAME_W: stored configuration. Frame k occupies bits [k*FRAME_W +: FRAME_W].
- `fabric_ff_en`, output, 1: equals `ff_en & cfg_done`, combinational.
- `cfg_done`, output, 1: all frames loaded in order.
- `cfg_err`, output, 1: sticky protocol error.
- `err_code`, output, 2: error cause. 01 = multi-hot `configs_en`; 10 = out-of-order frame; 11 = truncated load.
- `frames_loaded`, output, `$clog2(NUM_FRAMES+1)`: count of distinct frames written in the current load.
- `rd_data`, output, FRAME_W: readback data.
- `rd_valid`, output, 1: `rd_data` is valid.

## Operation
- **States:** IDLE, LOAD, DONE, ERR. `idx` is the index of the single set bit of `configs_en`. `last` is the register holding the last written index.
- **Any state except ERR, `configs_en` has more than one bit set:** go to ERR with `err_code`=01. No write occurs.
- **IDLE**
  - `configs_en`=0: stay in IDLE.
  - idx=0: write frame 0 and go to LOAD.
  - Any other idx: go to ERR with `err_code`=10. No write occurs.
- **LOAD**
  - idx==last: rewrite frame `last`. The last write wins; the loader holds data for 2 cycles and frame 0 is selected before its data arrives.
  - idx==last+1: write frame idx, increment `frames_loaded`, set `last`=idx.
  - Any other nonzero idx: go to ERR with `err_code`=10.
  - `configs_en`=0 with last==NUM_FRAMES-1: go to DONE.
  - `configs_en`=0 with last<NUM_FRAMES-1: go to ERR with `err_code`=11.
- **DONE**
  - `configs_en`=0: stay in DONE.
  - idx=0: start a reload. Clear `frames_loaded` to 1, write frame 0, go to LOAD, and drop `cfg_done`.
  - Any other idx: go to ERR with `err_code`=10.
- **ERR**
  - Absorbing state until `rst`. No frame writes are accepted.
  - `err_code` holds the first cause.
  - `config_bits` retains its contents.
- **Frame write:** `config_bits` frame idx <= `configs_in`. `frames_loaded` counts index advances, plus 1 for frame 0.
- **Readback:** operates in every state. `rd_en` with `rd_addr`<NUM_FRAMES gives `rd_data` = stored frame and `rd_valid`=1 on the next cycle. Out-of-range `rd_addr` gives `rd_data`=0 and `rd_valid`=1. A same-cycle write to the read frame returns the old data.

## Timing
- **Reset:** synchronous. Sets state to IDLE and `last` to 0. Clears `config_bits`, `rd_data`, `rd_valid`, `cfg_done`, `cfg_err`, `err_code` and `frames_loaded` to 0. `rst` has priority over all other inputs. Reset mid-load discards all loaded frames.
- **Frame write:** visible on `config_bits` 1 cycle after the sampling edge.
- **`cfg_done`:** rises 1 cycle after the first edge that samples `configs_en`=0 following frame NUM_FRAMES-1. The reload case falls 1 cycle after idx=0 is sampled in DONE.
- **`cfg_err` and `err_code`:** valid 1 cycle after the offending edge.
- **`fabric_ff_en`:** follows `ff_en` combinationally, masked by registered `cfg_done`.
- **Readback latency:** 1 cycle. `rd_valid` is a 1-cycle pulse per request. Back-to-back requests are allowed.

## Test plan
- **Normal load:** drive frame k data = {7{k[31:0]}}, each held 2 cycles, en shifting 1 through bit 42, then 0. Required: `cfg_done`=1, `frames_loaded`=43, `cfg_err`=0, each frame k of `config_bits` equals its pattern. With `ff_en`=1, `fabric_ff_en`=1 only after done.
- **Multi-hot:** in LOAD at last=5, `configs_en`=0b11 << 6. Required: `cfg_err`=1, `err_code`=01, frame 6 not written, `cfg_done` stays 0.
- **Skip and truncation:** jump from frame 3 to frame 5, giving `err_code`=10. In a separate run, drop en to 0 after frame 20, giving `err_code`=11 and `frames_loaded`=21.
- **Reload:** from DONE, en=1 with `configs_in`=all-ones. Required: `cfg_done`=0 the next cycle, `frames_loaded`=1, frame 0 = all-ones, frames 1-42 unchanged.
- **Reset mid-load:** `rst` for 1 cycle at frame 10. Required: all outputs 0, state IDLE. A subsequent full load completes normally.
- **Readback:**
  - After a normal load, `rd_en` with `rd_addr`=42 gives `rd_valid`=1 one cycle later with frame 42 data.
  - `rd_addr`=50 gives `rd_data`=0 with `rd_valid`=1.
  - Readback during ERR returns the retained data.
